uart16550_fifo_ctrl: RTL

- Control block for the RX and TX FIFOs of the 16550 UART.
- Decodes FCR writes into FIFO enable, self-clearing RX/TX FIFO resets, DMA mode and the RX trigger level.
- Runs the RX character-timeout timer: 4 character times of RX-FIFO inactivity while the FIFO holds data.
- Sits between the APB register file and the two FIFO instances.

---
 rtl/uart16550_pkg.sv | 29 ++
 rtl/uart16550_fifo_ctrl_rx_timeout.sv | 49 ++++
 rtl/uart16550_fifo_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/uart16550_pkg.sv
// Shared FCR field indices, trigger-code encoding and character-length helper
// for the 16550 FIFO control slice.
package uart16550_pkg;

  localparam int unsigned FCR_ENA     = 0;
  localparam int unsigned FCR_RXRST   = 1;
  localparam int unsigned FCR_TXRST   = 2;
  localparam int unsigned FCR_DMA     = 3;
  localparam int unsigned FCR_TRG_LO  = 6;
  localparam int unsigned FCR_TRG_HI  = 7;

  localparam int unsigned CHAR_BITS_W = 4;
  localparam int unsigned TMO_CNT_W   = 10;

  typedef enum logic [1:0] {
    TRG_1 = 2'd0,
    TRG_Q = 2'd1,
    TRG_H = 2'd2,
    TRG_F = 2'd3
  } trg_code_e;

  // start + (5+wls) data + parity + stop; 1.5 stop bits are rounded up to 2
  function automatic logic [CHAR_BITS_W-1:0] char_bits(input logic [1:0] wls,
                                                        input logic       stb,
                                                        input logic       pen);
    return CHAR_BITS_W'(7) + CHAR_BITS_W'(wls) + CHAR_BITS_W'(pen) + CHAR_BITS_W'(stb);
  endfunction

endpackage

// File: rtl/uart16550_fifo_ctrl_rx_timeout.sv
// RX character-timeout timer: counts 16x baud ticks of RX-FIFO inactivity and
// flags a timeout after four character times.
module uart16550_fifo_ctrl_rx_timeout
  import uart16550_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   bclk_ena_i,
  input  logic                   clr_i,
  input  logic [CHAR_BITS_W-1:0] char_bits_i,
  output logic                   timeout_o
);

  logic [TMO_CNT_W-1:0] thr;
  logic [TMO_CNT_W-1:0] cnt_q, cnt_d;
  logic                 tmo_q, tmo_d;

  // 4 characters x 16 ticks per bit
  assign thr = TMO_CNT_W'(char_bits_i) << 6;

  always_comb begin
    cnt_d = cnt_q;
    tmo_d = tmo_q;
    if (clr_i) begin
      cnt_d = '0;
      tmo_d = 1'b0;
    end else begin
      if (bclk_ena_i && (cnt_q < thr)) begin
        cnt_d = cnt_q + TMO_CNT_W'(1);
      end
      if (cnt_q >= thr) begin
        tmo_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign timeout_o = tmo_q;

endmodule

// File: rtl/uart16550_fifo_ctrl.sv
// 16550 FIFO control: FCR decode, self-clearing FIFO resets, trigger level,
// RX timeout and optional DMA ready outputs (enabled by UART16550_DMA_EN).
module uart16550_fifo_ctrl
  import uart16550_pkg::*;
#(
  parameter  int unsigned FIFO_DEPTH = 16,
  localparam int unsigned TW         = $clog2(FIFO_DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          fcr_we_i,
  input  logic [7:0]    fcr_d_i,
  input  logic [1:0]    lcr_wls_i,
  input  logic          lcr_stb_i,
  input  logic          lcr_pen_i,
  input  logic          bclk_ena_i,
  input  logic          rx_push_i,
  input  logic          rx_pop_i,
  input  logic          rx_empty_i,
  input  logic          rx_trigger_i,
  input  logic          tx_empty_i,
  input  logic          tx_full_i,
  output logic          fifo_ena_o,
  output logic          rx_fifo_rst_o,
  output logic          tx_fifo_rst_o,
  output logic [TW-1:0] rx_trigger_lvl_o,
  output logic          dma_mode_o,
  output logic          rx_timeout_o,
  output logic          rxrdy_o,
  output logic          txrdy_o
);

  function automatic logic [TW-1:0] trg_level(input trg_code_e code);
    case (code)
      TRG_Q:   return TW'(FIFO_DEPTH / 4);
      TRG_H:   return TW'(FIFO_DEPTH / 2);
      TRG_F:   return TW'(FIFO_DEPTH - 2);
      default: return TW'(1);
    endcase
  endfunction

  logic          fifo_ena_q, fifo_ena_d;
  logic          dma_q, dma_d;
  logic [TW-1:0] lvl_q, lvl_d;
  logic          rx_rst_q, rx_rst_d;
  logic          tx_rst_q, tx_rst_d;
  logic          ena_chg;
  logic          tmo_clr;
  logic          unused_fcr;

  assign ena_chg    = fcr_d_i[FCR_ENA] ^ fifo_ena_q;
  assign unused_fcr = ^fcr_d_i[5:4];

  // FCR decode; reset bits only ever produce a one-cycle pulse
  always_comb begin
    fifo_ena_d = fifo_ena_q;
    dma_d      = dma_q;
    lvl_d      = lvl_q;
    rx_rst_d   = 1'b0;
    tx_rst_d   = 1'b0;
    if (fcr_we_i) begin
      fifo_ena_d = fcr_d_i[FCR_ENA];
      dma_d      = fcr_d_i[FCR_DMA];
      lvl_d      = trg_level(trg_code_e'(fcr_d_i[FCR_TRG_HI:FCR_TRG_LO]));
      rx_rst_d   = fcr_d_i[FCR_RXRST] | ena_chg;
      tx_rst_d   = fcr_d_i[FCR_TXRST] | ena_chg;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fifo_ena_q <= 1'b0;
      dma_q      <= 1'b0;
      lvl_q      <= TW'(1);
      rx_rst_q   <= 1'b1;
      tx_rst_q   <= 1'b1;
    end else begin
      fifo_ena_q <= fifo_ena_d;
      dma_q      <= dma_d;
      lvl_q      <= lvl_d;
      rx_rst_q   <= rx_rst_d;
      tx_rst_q   <= tx_rst_d;
    end
  end

  assign fifo_ena_o       = fifo_ena_q;
  assign dma_mode_o       = dma_q;
  assign rx_trigger_lvl_o = lvl_q;
  assign rx_fifo_rst_o    = rx_rst_q;
  assign tx_fifo_rst_o    = tx_rst_q;

  assign tmo_clr = rx_push_i | rx_pop_i | rx_rst_q | rx_empty_i | ~fifo_ena_q;

  uart16550_fifo_ctrl_rx_timeout u_rx_timeout (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .bclk_ena_i  (bclk_ena_i),
    .clr_i       (tmo_clr),
    .char_bits_i (char_bits(lcr_wls_i, lcr_stb_i, lcr_pen_i)),
    .timeout_o   (rx_timeout_o)
  );

`ifdef UART16550_DMA_EN
  logic rxrdy_q, rxrdy_d;
  logic txrdy_q, txrdy_d;
  logic dma_mode1;

  assign dma_mode1 = dma_q & fifo_ena_q;

  // mode 0 mirrors FIFO flags; mode 1 is set/clear with clear winning
  always_comb begin
    rxrdy_d = rxrdy_q;
    txrdy_d = txrdy_q;
    if (!dma_mode1) begin
      rxrdy_d = ~rx_empty_i;
      txrdy_d = tx_empty_i;
    end else begin
      if (rx_empty_i) begin
        rxrdy_d = 1'b0;
      end else if (rx_trigger_i || rx_timeout_o) begin
        rxrdy_d = 1'b1;
      end
      if (tx_full_i) begin
        txrdy_d = 1'b0;
      end else if (tx_empty_i) begin
        txrdy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rxrdy_q <= 1'b0;
      txrdy_q <= 1'b0;
    end else begin
      rxrdy_q <= rxrdy_d;
      txrdy_q <= txrdy_d;
    end
  end

  assign rxrdy_o = rxrdy_q;
  assign txrdy_o = txrdy_q;
`else
  logic unused_dma_in;
  assign unused_dma_in = rx_trigger_i ^ tx_empty_i ^ tx_full_i;
  assign rxrdy_o       = 1'b0;
  assign txrdy_o       = 1'b0;
`endif

endmodule
